// File: rtl/usb_phy_pkg.sv
// Shared definitions for the full-speed USB receive path: line-state codes,
// receive FSM states and bit-stuffing limits.
package usb_phy_pkg;

    // Line-state codes are {D+, D-} after synchronisation.
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;

    localparam int STUFF_LIMIT        = 6;
    localparam int DEFAULT_OVERSAMPLE = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_EOP   = 3'd3,
        ST_ABORT = 3'd4
    } rx_state_e;

endpackage

// File: rtl/usb_rx_decoder_if.sv
// Byte stream from the USB receive decoder to the packet layer.
interface usb_rx_decoder_if;

    // rx_valid_o is a one-cycle strobe with no ready: the packet layer must take
    // every byte in the cycle it is offered. rx_active_o frames a packet, and
    // rx_error_o / rx_eop_o are one-cycle strobes that never share a cycle with rx_valid_o.
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_active_o;
    logic       rx_error_o;
    logic       rx_eop_o;

    modport master (output rx_data_o, rx_valid_o, rx_active_o, rx_error_o, rx_eop_o);
    modport slave  (input  rx_data_o, rx_valid_o, rx_active_o, rx_error_o, rx_eop_o);

endinterface

// File: rtl/usb_rx_dpll.sv
// Pad synchroniser, line-state decode and bit-centre strobe recovery for the
// oversampled USB D+/D- pair.
module usb_rx_dpll
    import usb_phy_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_dp_i,
    input  logic       rx_dn_i,
    output logic [1:0] line_state,
    output logic       bit_stb
);

    localparam int             CW      = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  CNT_MAX = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0]  STB_AT  = CW'(OVERSAMPLE / 2 - 1);

    logic [1:0]    dp_sync;
    logic [1:0]    dn_sync;
    logic [1:0]    ls_sync;
    logic [1:0]    ls_q;
    logic [CW-1:0] cnt_q;

    assign ls_sync = {dp_sync[1], dn_sync[1]};

    // Synchronisers reset to J so leaving reset on an idle bus is not an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dp_sync <= 2'b11;
            dn_sync <= 2'b00;
            ls_q    <= LS_J;
            cnt_q   <= '0;
        end else begin
            dp_sync <= {dp_sync[0], rx_dp_i};
            dn_sync <= {dn_sync[0], rx_dn_i};
            ls_q    <= ls_sync;
            if (ls_sync != ls_q || cnt_q == CNT_MAX) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign line_state = ls_q;
    assign bit_stb    = (cnt_q == STB_AT);

endmodule

// File: rtl/usb_rx_decoder.sv
// Full-speed USB receive decoder: NRZI decode, SYNC detect, unstuffing, byte
// assembly and EOP detection. Build option USB_RX_LINESTATE_EN adds line_state_o.
module usb_rx_decoder
    import usb_phy_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int IDLE_BITS  = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rx_dp_i,
    input  logic                    rx_dn_i,
    input  logic                    rx_en_i,
    usb_rx_decoder_if.master        rx,
`ifdef USB_RX_LINESTATE_EN
    output logic [1:0]              line_state_o,
`endif
    output rx_state_e               dbg_state
);

    localparam int            IW        = $clog2(IDLE_BITS + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);
    localparam logic [2:0]    STUFF_AT  = 3'(STUFF_LIMIT);

    logic [1:0] ls;
    logic       bit_stb;

    usb_rx_dpll #(.OVERSAMPLE(OVERSAMPLE)) u_dpll (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_dp_i    (rx_dp_i),
        .rx_dn_i    (rx_dn_i),
        .line_state (ls),
        .bit_stb    (bit_stb)
    );

    rx_state_e     state_q, state_d;
    logic [1:0]    prev_jk_q, prev_jk_d;
    logic [2:0]    ones_q, ones_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          se0_seen_q, se0_seen_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          active_q, active_d;
    logic          error_q, error_d;
    logic          eop_q, eop_d;

    logic is_jk;
    logic nrzi_bit;
    logic go_abort;

    always_comb begin
        state_d    = state_q;
        prev_jk_d  = prev_jk_q;
        ones_d     = ones_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        idle_cnt_d = idle_cnt_q;
        se0_seen_d = se0_seen_q;
        data_d     = data_q;
        active_d   = active_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        eop_d      = 1'b0;
        go_abort   = 1'b0;
        is_jk      = (ls == LS_J) || (ls == LS_K);
        nrzi_bit   = (ls == prev_jk_q);

        if (!rx_en_i) begin
            state_d   = ST_IDLE;
            active_d  = 1'b0;
            prev_jk_d = LS_J;
        end else if (bit_stb) begin
            if (is_jk) begin
                prev_jk_d = ls;
            end
            case (state_q)
                ST_IDLE: begin
                    if (ls == LS_K) state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (!is_jk) begin
                        state_d = ST_IDLE;
                    end else if (nrzi_bit) begin
                        state_d   = ST_DATA;
                        active_d  = 1'b1;
                        ones_d    = 3'd1;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    if (ls == LS_SE0) begin
                        state_d = ST_EOP;
                        error_d = (bit_cnt_q != 3'd0);
                    end else if (ls == LS_SE1) begin
                        go_abort = 1'b1;
                    end else if (ones_q == STUFF_AT) begin
                        // Stuff position: a 0 is discarded, a 1 breaks the stuffing rule.
                        if (nrzi_bit) go_abort = 1'b1;
                        else          ones_d   = 3'd0;
                    end else begin
                        shift_d   = {nrzi_bit, shift_q[7:1]};
                        ones_d    = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d  = shift_d;
                            valid_d = 1'b1;
                        end
                    end
                end
                ST_EOP: begin
                    if (ls == LS_J) begin
                        eop_d    = 1'b1;
                        active_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    if (ls == LS_J) begin
                        if (se0_seen_q || idle_cnt_q == IDLE_LAST) state_d = ST_IDLE;
                        else idle_cnt_d = idle_cnt_q + IW'(1);
                    end else begin
                        idle_cnt_d = '0;
                        se0_seen_d = (ls == LS_SE0);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (go_abort) begin
                state_d    = ST_ABORT;
                error_d    = 1'b1;
                active_d   = 1'b0;
                idle_cnt_d = '0;
                se0_seen_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            prev_jk_q  <= LS_J;
            ones_q     <= 3'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            idle_cnt_q <= '0;
            se0_seen_q <= 1'b0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
            error_q    <= 1'b0;
            eop_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_jk_q  <= prev_jk_d;
            ones_q     <= ones_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            idle_cnt_q <= idle_cnt_d;
            se0_seen_q <= se0_seen_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
            error_q    <= error_d;
            eop_q      <= eop_d;
        end
    end

`ifdef USB_RX_LINESTATE_EN
    logic [1:0] line_state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) line_state_q <= LS_J;
        else       line_state_q <= ls;
    end

    assign line_state_o = line_state_q;
`endif

    assign rx.rx_data_o   = data_q;
    assign rx.rx_valid_o  = valid_q;
    assign rx.rx_active_o = active_q;
    assign rx.rx_error_o  = error_q;
    assign rx.rx_eop_o    = eop_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: NRZI/stuffing encoder builds line symbols,
// a negedge monitor collects bytes and strobes, and a scoreboard compares them.
module tb_usb_rx_decoder;
    import usb_phy_pkg::*;

    localparam int OV = 4;

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       rx_en = 1'b1;
    logic [1:0] line  = LS_J;
    rx_state_e  dbg_state;
`ifdef USB_RX_LINESTATE_EN
    logic [1:0] ls_obs;
`endif

    always #5 clk = ~clk;

    usb_rx_decoder_if rx_bus ();

    usb_rx_decoder #(.OVERSAMPLE(OV), .IDLE_BITS(7)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_dp_i      (line[1]),
        .rx_dn_i      (line[0]),
        .rx_en_i      (rx_en),
        .rx           (rx_bus),
`ifdef USB_RX_LINESTATE_EN
        .line_state_o (ls_obs),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int n_err  = 0;
    int n_eop  = 0;
    int n_rise = 0;
    int n_both = 0;
    logic act_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_bus.rx_valid_o) got_q.push_back(rx_bus.rx_data_o);
        if (rx_bus.rx_error_o) n_err++;
        if (rx_bus.rx_eop_o) n_eop++;
        if (rx_bus.rx_valid_o && rx_bus.rx_eop_o) n_both++;
        if (rx_bus.rx_active_o && !act_prev) n_rise++;
        act_prev = rx_bus.rx_active_o;
    end

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        n_err  = 0;
        n_eop  = 0;
        n_rise = 0;
        n_both = 0;
    endtask

    task automatic end_pkt(input string tag, input int exp_err, input int exp_eop);
        check_eq({tag, " byte count"}, got_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < got_q.size()) check_eq($sformatf("%s byte %0d", tag, i), got_q[i], exp_q[i]);
        end
        check_eq({tag, " error pulses"}, n_err, exp_err);
        check_eq({tag, " eop pulses"}, n_eop, exp_eop);
        check_eq({tag, " active rises"}, n_rise, 1);
        check_eq({tag, " valid+eop same cycle"}, n_both, 0);
        check_eq({tag, " active at end"}, rx_bus.rx_active_o, 0);
        check_eq({tag, " state at end"}, dbg_state, ST_IDLE);
        clear_mon();
    endtask

    // ---------------- driver: NRZI / stuffing encoder ----------------
    logic [1:0] sym_q[$];
    logic [1:0] lvl  = LS_J;
    int         ones = 0;
    int         jit_tab[4] = '{1, 0, -1, 0};

    task automatic push_ls(input logic [1:0] ls, input int n);
        for (int i = 0; i < n; i++) sym_q.push_back(ls);
        if (ls == LS_J || ls == LS_K) lvl = ls;
    endtask

    task automatic push_bit(input bit b, input bit stuff);
        if (!b) lvl = (lvl == LS_J) ? LS_K : LS_J;
        sym_q.push_back(lvl);
        ones = b ? ones + 1 : 0;
        if (stuff && ones == 6) begin
            lvl = (lvl == LS_J) ? LS_K : LS_J;
            sym_q.push_back(lvl);
            ones = 0;
        end
    endtask

    task automatic push_byte(input logic [7:0] v, input bit stuff);
        for (int i = 0; i < 8; i++) push_bit(v[i], stuff);
    endtask

    task automatic push_sync();
        for (int i = 0; i < 7; i++) push_bit(1'b0, 1'b0);
        push_bit(1'b1, 1'b0);
    endtask

    // Edges between J and K optionally shift by the jitter table; consecutive
    // edge offsets differ by at most one clock so every bit stays 3..5 clocks.
    task automatic play(input bit jitter);
        int n;
        int e;
        int offs[];
        n = sym_q.size();
        e = 0;
        offs = new[n + 1];
        for (int i = 0; i <= n; i++) begin
            offs[i] = 0;
            if (jitter && i > 0 && i < n && sym_q[i] != sym_q[i-1] &&
                (sym_q[i] == LS_J || sym_q[i] == LS_K) &&
                (sym_q[i-1] == LS_J || sym_q[i-1] == LS_K)) begin
                offs[i] = jit_tab[e % 4];
                e++;
            end
        end
        for (int i = 0; i < n; i++) begin
            line = sym_q[i];
            repeat (OV + offs[i+1] - offs[i]) @(negedge clk);
        end
        sym_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset data", rx_bus.rx_data_o, 0);
        check_eq("reset valid", rx_bus.rx_valid_o, 0);
        check_eq("reset active", rx_bus.rx_active_o, 0);
        check_eq("reset error", rx_bus.rx_error_o, 0);
        check_eq("reset eop", rx_bus.rx_eop_o, 0);
        check_eq("reset state", dbg_state, ST_IDLE);
        clear_mon();

        // Plain single-byte packet.
        push_ls(LS_J, 8); push_sync(); push_byte(8'hA5, 1'b1);
        push_ls(LS_SE0, 2); push_ls(LS_J, 8);
        play(1'b0);
        exp_q.push_back(8'hA5);
        end_pkt("a5 packet", 0, 1);

        // Stuffed zeros after six ones in 0xFF and 0x3F.
        push_ls(LS_J, 8); push_sync(); push_byte(8'hFF, 1'b1); push_byte(8'h3F, 1'b1);
        push_ls(LS_SE0, 2); push_ls(LS_J, 8);
        play(1'b0);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3F);
        end_pkt("stuffed packet", 0, 1);

        // Missing stuff bit: error, abort, then recovery after seven idle J bits.
        push_ls(LS_J, 8); push_sync(); push_byte(8'hFF, 1'b0);
        play(1'b0);
        check_eq("stuff err state", dbg_state, ST_ABORT);
        check_eq("stuff err active", rx_bus.rx_active_o, 0);
        push_ls(LS_J, 3);
        play(1'b0);
        check_eq("abort after 3 J", dbg_state, ST_ABORT);
        push_ls(LS_J, 9);
        play(1'b0);
        end_pkt("stuff error", 1, 0);

        // Byte followed by three stray bits: misaligned EOP.
        push_ls(LS_J, 8); push_sync(); push_byte(8'h12, 1'b1);
        push_bit(1'b1, 1'b1); push_bit(1'b0, 1'b1); push_bit(1'b1, 1'b1);
        push_ls(LS_SE0, 2); push_ls(LS_J, 8);
        play(1'b0);
        exp_q.push_back(8'h12);
        end_pkt("misaligned", 1, 1);

        // Every J/K edge jittered by up to one clock.
        push_ls(LS_J, 8); push_sync(); push_byte(8'h5A, 1'b1); push_byte(8'hC3, 1'b1);
        push_ls(LS_SE0, 2); push_ls(LS_J, 8);
        play(1'b1);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        end_pkt("jitter", 0, 1);

        // One-clock reset in the middle of a byte.
        push_ls(LS_J, 8); push_sync();
        for (int i = 0; i < 4; i++) push_bit(1'b0, 1'b1);
        play(1'b0);
        check_eq("mid-byte active before rst", rx_bus.rx_active_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst data", rx_bus.rx_data_o, 0);
        check_eq("rst valid", rx_bus.rx_valid_o, 0);
        check_eq("rst active", rx_bus.rx_active_o, 0);
        check_eq("rst error", rx_bus.rx_error_o, 0);
        check_eq("rst eop", rx_bus.rx_eop_o, 0);
        check_eq("rst state", dbg_state, ST_IDLE);
        clear_mon();
        for (int i = 0; i < 4; i++) push_bit(1'b1, 1'b1);
        push_ls(LS_SE0, 2); push_ls(LS_J, 8);
        play(1'b0);
        check_eq("remainder after rst valid count", got_q.size(), 0);
        clear_mon();
        push_ls(LS_J, 8); push_sync(); push_byte(8'h3C, 1'b1);
        push_ls(LS_SE0, 2); push_ls(LS_J, 8);
        play(1'b0);
        exp_q.push_back(8'h3C);
        end_pkt("after rst", 0, 1);

        // Receive disabled mid-packet: forced idle, no strobes.
        push_ls(LS_J, 8); push_sync();
        for (int i = 0; i < 4; i++) push_bit(1'b0, 1'b1);
        play(1'b0);
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("disable active", rx_bus.rx_active_o, 0);
        check_eq("disable state", dbg_state, ST_IDLE);
        push_ls(LS_SE0, 2); push_ls(LS_J, 8);
        play(1'b0);
        check_eq("disable valid count", got_q.size(), 0);
        check_eq("disable error pulses", n_err, 0);
        check_eq("disable eop pulses", n_eop, 0);
        rx_en = 1'b1;
        clear_mon();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule

// File: doc/usb_rx_decoder.md
Name: usb_rx_decoder

Overview:
Full-speed USB 1.1 receive decoder. It sits directly downstream of the Pmod D+/D- pad/tristate stage and turns the raw differential line into framed bytes.
- Recovers the bit clock from the oversampled line.
- Performs NRZI decode, SYNC detection, bit unstuffing, LSB-first byte assembly and EOP detection.
- Hands bytes with valid/active/error/EOP flags to the packet layer.

Parameters:
OVERSAMPLE, 4, clk_i cycles per USB bit (48 MHz for 12 Mb/s); must be even and >= 4
IDLE_BITS, 7, consecutive J bit-times that end the ABORT state

Ports:
clk_i  input  1  system clock, OVERSAMPLE x bit rate
rst_i  input  1  synchronous, active-high reset
rx_dp_i  input  1  raw D+ from pad, asynchronous
rx_dn_i  input  1  raw D- from pad, asynchronous
rx_en_i  input  1  receive enable; low forces IDLE (transmit in progress)
rx_data_o  output  8  assembled byte, LSB = first bit received
rx_valid_o  output  1  one-cycle strobe, rx_data_o valid
rx_active_o  output  1  high from SYNC completion to EOP/abort
rx_error_o  output  1  one-cycle strobe: stuff error, SE1, or byte misalignment at EOP
rx_eop_o  output  1  one-cycle strobe at end of a good or misaligned packet

Behaviour:
- Reset: all outputs 0; FSM = IDLE; prev line state = J; DPLL counter = 0; ones count = 0.
- Input sync: 2-flop synchronizer per line. Line state from synced pair: J = 10, K = 01, SE0 = 00, SE1 = 11.
- DPLL:
  - Counter runs 0..OVERSAMPLE-1 and wraps.
  - Any change of synced line state reloads the counter to 0.
  - Bit strobe fires when counter == OVERSAMPLE/2-1.
  - All decoding below acts only on strobe cycles.
- NRZI: decoded bit = 1 if the sampled state equals the previous sampled J/K state, else 0. The previous state updates only on J/K samples.
- FSM states: IDLE, SYNC, DATA, EOP, ABORT.
  - IDLE: K sample -> SYNC. Anything else stays in IDLE.
  - SYNC: decoded 0 stays in SYNC. Decoded 1 (KK) -> DATA; rx_active_o rises the next cycle; ones count = 1; bit count = 0. SE0 -> IDLE, no error.
  - DATA:
    - Decoded bit with ones count == 6: the bit is a stuff bit. If 0, drop it and reset the ones count. If 1, pulse rx_error_o and go to ABORT.
    - Otherwise shift the bit in at bit[7] (shift right) and update the ones count (1 increments, 0 clears).
    - On the 8th bit, rx_data_o/rx_valid_o update one clk after that strobe.
    - SE0 -> EOP. If bit count != 0, also pulse rx_error_o (misaligned).
    - SE1 -> rx_error_o, then ABORT.
  - EOP: waits for a J sample, then pulses rx_eop_o, drops rx_active_o in the same cycle and goes to IDLE. SE0 of any length is accepted (bus reset is not this block's concern).
  - ABORT: rx_active_o low on entry. Returns to IDLE after IDLE_BITS consecutive J samples, or after SE0 followed by J. rx_eop_o is not pulsed.
- Simultaneous events:
  - Final byte completing on the same strobe as a stuff error: the stuff check takes priority and the byte is not emitted.
  - rx_valid_o and rx_eop_o never assert in the same cycle.
- rx_en_i low: synchronously forces IDLE; rx_active_o drops the next cycle; no eop/error pulses.
- rst_i mid-packet: next cycle all outputs are at their reset values; no partial byte is emitted.
- Latency: pad edge to decoded-bit strobe is at most 2 + OVERSAMPLE/2 clks.

Optional Feature:
USB_RX_LINESTATE_EN:
- Defined: adds output line_state_o [1:0], the registered synced line state (J/K/SE0/SE1 encoding above), updated every clk, reset 2'b10 (J).
- Undefined: the port and its register are absent; behaviour is otherwise identical.

Decomposition:
- Package usb_phy_pkg holds:
  - Line-state encodings LS_J, LS_K, LS_SE0, LS_SE1.
  - FSM state enum.
  - STUFF_LIMIT = 6.
  - Default OVERSAMPLE.
- One sub-module: usb_rx_dpll (synchronizer, line-state decode, bit strobe). Outputs line_state and bit_stb.

Test Plan:
- OVERSAMPLE=4. Idle J, then SYNC KJKJKJKK, byte 0xA5, SE0 x2 bits, J -> rx_active_o rises after the last K; one rx_valid_o with 0xA5; rx_eop_o once; no error.
- Byte 0xFF then 0x3F: stuffed 0 after six 1s -> bytes 0xFF and 0x3F exactly; no error.
- Six 1s followed by a 1 (no stuff bit) -> rx_error_o once; no rx_valid_o for that byte; rx_eop_o never pulses; return to IDLE after 7 J bits.
- SYNC + 0x12 + 3 bits + SE0/J -> rx_valid_o 0x12; rx_error_o and rx_eop_o both pulse.
- Line edges jittered by ±1 clk on every bit (OVERSAMPLE=4), payload 0x5A,0xC3 -> both bytes correct.
- rst_i for 1 clk mid-byte of a packet -> all outputs 0 next cycle; the remainder of the packet produces no rx_valid_o; the next full packet decodes correctly.
